// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
//   Session sequencer for one ATM terminal. It takes a card and PIN, asks the
//   card-handling block to look the PIN up, enforces the wrong-PIN retry limit
//   and the inactivity timeout, and runs inquiry/withdraw/deposit operations,
//   writing new balances back through op_done/updated_balance.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   card_in, card_number          card presence and number from the slot reader
//   psw_valid, password_input     one-cycle PIN entry strobe and PIN
//   op_valid, op_code, amount     one-cycle operation strobe, code, amount
//   ch_balance, ch_wrong_psw      lookup result from card handling
//   ch_card_number, ch_password   latched card/PIN presented to card handling
//   ch_card_in                    one-cycle lookup request
//   op_done, updated_balance      one-cycle balance write to card handling
//   balance                       session balance shown to the user
//   txn_ok, txn_reject            operation accepted / refused pulses
//   wrong_psw, card_retained      PIN rejected (retry left) / card swallowed
//   card_eject, timeout           waiting for removal / inactivity eject pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no session; waits for a card (after a retain, for removal)
// GET_PSW  | card accepted, waiting for the PIN, inactivity timer running
// VERIFY   | lookup request to card handling (ch_card_in high)
// CHECK    | lookup result valid; count wrong PINs or open the session
// MENU     | waits for an operation, inactivity timer running
// UPDATE   | balance write cycle (op_done high)
// EJECT    | card_eject high until the card is removed
// RETAIN   | card swallowed; session cleared

module atm_session_ctrl #(
  parameter int CARD_WIDTH     = 6,
  parameter int PASSWORD_WIDTH = 16,
  parameter int BALANCE_WIDTH  = 20,
  parameter int USERS_NUM      = 10,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_in,
  input  logic [CARD_WIDTH-1:0]     card_number,
  input  logic                      psw_valid,
  input  logic [PASSWORD_WIDTH-1:0] password_input,
  input  logic                      op_valid,
  input  logic [1:0]                op_code,
  input  logic [BALANCE_WIDTH-1:0]  amount,
  input  logic [BALANCE_WIDTH-1:0]  ch_balance,
  input  logic                      ch_wrong_psw,
  output logic [CARD_WIDTH-1:0]     ch_card_number,
  output logic                      ch_card_in,
  output logic [PASSWORD_WIDTH-1:0] ch_password,
  output logic                      op_done,
  output logic [BALANCE_WIDTH-1:0]  updated_balance,
  output logic [BALANCE_WIDTH-1:0]  balance,
  output logic                      txn_ok,
  output logic                      txn_reject,
  output logic                      wrong_psw,
  output logic                      card_eject,
  output logic                      card_retained,
  output logic                      timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]         TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]         TRIES_LIM  = RW'(MAX_TRIES);
  localparam logic [CARD_WIDTH:0]   USERS_LIM  = (CARD_WIDTH + 1)'(USERS_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_PSW, S_VERIFY, S_CHECK, S_MENU, S_UPDATE, S_EJECT, S_RETAIN
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;         // down-counter, expires at zero
  logic [RW-1:0]     tries;
  logic              need_release;  // retained card must leave the slot first

  logic [BALANCE_WIDTH:0] dep_sum;
  logic [RW-1:0]          tries_nxt;
  logic                   card_known;
  logic                   wd_short;

  assign dep_sum    = {1'b0, balance} + {1'b0, amount};
  assign tries_nxt  = tries + RW'(1);
  assign card_known = {1'b0, card_number} < USERS_LIM;
  assign wd_short   = amount > balance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      timer           <= '0;
      tries           <= '0;
      need_release    <= 1'b0;
      ch_card_number  <= '0;
      ch_card_in      <= 1'b0;
      ch_password     <= '0;
      op_done         <= 1'b0;
      updated_balance <= '0;
      balance         <= '0;
      txn_ok          <= 1'b0;
      txn_reject      <= 1'b0;
      wrong_psw       <= 1'b0;
      card_eject      <= 1'b0;
      card_retained   <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      ch_card_in      <= 1'b0;
      op_done         <= 1'b0;
      updated_balance <= '0;
      txn_ok          <= 1'b0;
      txn_reject      <= 1'b0;
      wrong_psw       <= 1'b0;
      card_retained   <= 1'b0;
      timeout         <= 1'b0;

      // Card pulled mid-session: drop everything, nothing is written back.
      if (!card_in && (state inside {S_GET_PSW, S_VERIFY, S_CHECK, S_MENU})) begin
        state          <= S_IDLE;
        balance        <= '0;
        ch_card_number <= '0;
        ch_password    <= '0;
        tries          <= '0;
        timer          <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!card_in) begin
              need_release <= 1'b0;
            end else if (!need_release) begin
              if (card_known) begin
                ch_card_number <= card_number;
                timer          <= TIMER_LOAD;
                state          <= S_GET_PSW;
              end else begin
                card_eject <= 1'b1;
                state      <= S_EJECT;
              end
            end
          end

          S_GET_PSW: begin
            // PIN entry takes priority over a timer expiring in the same cycle.
            if (psw_valid) begin
              ch_password <= password_input;
              ch_card_in  <= 1'b1;
              state       <= S_VERIFY;
            end else if (timer == '0) begin
              timeout    <= 1'b1;
              card_eject <= 1'b1;
              state      <= S_EJECT;
            end else begin
              timer <= timer - TW'(1);
            end
          end

          S_VERIFY: state <= S_CHECK;

          S_CHECK: begin
            if (ch_wrong_psw) begin
              tries <= tries_nxt;
              if (tries_nxt == TRIES_LIM) begin
                card_retained <= 1'b1;
                state         <= S_RETAIN;
              end else begin
                wrong_psw <= 1'b1;
                timer     <= TIMER_LOAD;
                state     <= S_GET_PSW;
              end
            end else begin
              balance <= ch_balance;
              tries   <= '0;
              timer   <= TIMER_LOAD;
              state   <= S_MENU;
            end
          end

          S_MENU: begin
            if (op_valid) begin
              timer <= TIMER_LOAD;
              case (op_code)
                2'b00: txn_ok <= 1'b1;
                2'b01: begin
                  if (wd_short) begin
                    txn_reject <= 1'b1;
                  end else begin
                    updated_balance <= balance - amount;
                    op_done         <= 1'b1;
                    txn_ok          <= 1'b1;
                    state           <= S_UPDATE;
                  end
                end
                2'b10: begin
                  if (dep_sum[BALANCE_WIDTH]) begin
                    txn_reject <= 1'b1;
                  end else begin
                    updated_balance <= dep_sum[BALANCE_WIDTH-1:0];
                    op_done         <= 1'b1;
                    txn_ok          <= 1'b1;
                    state           <= S_UPDATE;
                  end
                end
                2'b11: begin
                  card_eject <= 1'b1;
                  state      <= S_EJECT;
                end
              endcase
            end else if (timer == '0) begin
              timeout    <= 1'b1;
              card_eject <= 1'b1;
              state      <= S_EJECT;
            end else begin
              timer <= timer - TW'(1);
            end
          end

          // The write is already on the bus this cycle; a pulled card only
          // ends the session after it.
          S_UPDATE: begin
            timer <= TIMER_LOAD;
            if (card_in) begin
              balance <= updated_balance;
              state   <= S_MENU;
            end else begin
              balance        <= '0;
              ch_card_number <= '0;
              ch_password    <= '0;
              tries          <= '0;
              state          <= S_IDLE;
            end
          end

          S_EJECT: begin
            if (!card_in) begin
              card_eject     <= 1'b0;
              balance        <= '0;
              ch_card_number <= '0;
              ch_password    <= '0;
              tries          <= '0;
              timer          <= '0;
              state          <= S_IDLE;
            end
          end

          S_RETAIN: begin
            balance        <= '0;
            ch_card_number <= '0;
            ch_password    <= '0;
            tries          <= '0;
            timer          <= '0;
            need_release   <= 1'b1;
            state          <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
module tb_atm_session_ctrl;
  localparam int CW = 6, PW = 16, BW = 20, USERS = 10, MAXT = 3, TO = 1000;
  localparam longint LIM = (64'd1 << BW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic card_in, psw_valid, op_valid, ch_wrong_psw;
  logic [CW-1:0] card_number;
  logic [PW-1:0] password_input;
  logic [1:0]    op_code;
  logic [BW-1:0] amount, ch_balance;
  logic [CW-1:0] ch_card_number;
  logic [PW-1:0] ch_password;
  logic [BW-1:0] updated_balance, balance;
  logic ch_card_in, op_done, txn_ok, txn_reject, wrong_psw, card_eject, card_retained, timeout;

  atm_session_ctrl #(
    .CARD_WIDTH(CW), .PASSWORD_WIDTH(PW), .BALANCE_WIDTH(BW),
    .USERS_NUM(USERS), .MAX_TRIES(MAXT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
    .psw_valid(psw_valid), .password_input(password_input),
    .op_valid(op_valid), .op_code(op_code), .amount(amount),
    .ch_balance(ch_balance), .ch_wrong_psw(ch_wrong_psw),
    .ch_card_number(ch_card_number), .ch_card_in(ch_card_in),
    .ch_password(ch_password), .op_done(op_done),
    .updated_balance(updated_balance), .balance(balance),
    .txn_ok(txn_ok), .txn_reject(txn_reject), .wrong_psw(wrong_psw),
    .card_eject(card_eject), .card_retained(card_retained), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // cycles-high counters, sampled away from the active edge
  int c_op_done = 0, c_wrong = 0, c_ret = 0, c_to = 0, c_eject = 0;
  always @(negedge clk) begin
    if (op_done)       c_op_done++;
    if (wrong_psw)     c_wrong++;
    if (card_retained) c_ret++;
    if (timeout)       c_to++;
    if (card_eject)    c_eject++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input logic [1:0] code, input logic [BW-1:0] amt);
    op_valid = 1'b1; op_code = code; amount = amt;
    step();
    op_valid = 1'b0;
  endtask

  task automatic login(input logic [CW-1:0] card, input logic [PW-1:0] pin, input logic [BW-1:0] bal);
    ch_balance = bal; ch_wrong_psw = 1'b0;
    card_number = card; card_in = 1'b1;
    step();
    psw_valid = 1'b1; password_input = pin;
    step();
    psw_valid = 1'b0;
    check("lookup_req", 32'(ch_card_in), 32'd1);
    check("lookup_card", 32'(ch_card_number), 32'(card));
    check("lookup_pin", 32'(ch_password), 32'(pin));
    step();
    check("lookup_one_cycle", 32'(ch_card_in), 32'd0);
    step();
    check("session_balance", 32'(balance), 32'(bal));
  endtask

  task automatic logout();
    do_op(2'b11, '0);
    check("exit_eject", 32'(card_eject), 32'd1);
    step(2);
    check("eject_held", 32'(card_eject), 32'd1);
    card_in = 1'b0;
    step();
    check("eject_released", 32'(card_eject), 32'd0);
    check("eject_clears_balance", 32'(balance), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, snap2, op, sel;
    longint mbal, a, nb;
    logic exp_upd, exp_rej, exp_ok;
    logic [CW-1:0] bad_cards [2];

    rst = 1'b1; card_in = 1'b0; card_number = '0; psw_valid = 1'b0;
    password_input = '0; op_valid = 1'b0; op_code = '0; amount = '0;
    ch_balance = '0; ch_wrong_psw = 1'b0;
    step(2);
    check("rst_outputs", 32'({ch_card_in, op_done, txn_ok, txn_reject, wrong_psw,
                              card_eject, card_retained, timeout}), 32'd0);
    check("rst_balance", 32'(balance), 32'd0);
    check("rst_latched", 32'({ch_card_number, ch_password}), 32'd0);
    rst = 1'b0;
    step();

    // good session: withdraw 400 from 1000
    login(6'd3, 16'h1234, 20'd1000);
    snap = c_op_done;
    do_op(2'b01, 20'd400);
    check("wd_op_done", 32'(op_done), 32'd1);
    check("wd_updated", 32'(updated_balance), 32'd600);
    check("wd_txn_ok", 32'(txn_ok), 32'd1);
    do_op(2'b00, '0);  // lands in the write cycle: must be ignored
    check("wd_op_done_end", 32'(op_done), 32'd0);
    check("wd_balance", 32'(balance), 32'd600);
    check("update_strobe_ignored", 32'(txn_ok), 32'd0);
    check("wd_single_write", 32'(c_op_done - snap), 32'd1);
    logout();

    // retry limit
    snap = c_wrong; snap2 = c_ret;
    ch_wrong_psw = 1'b1; card_number = 6'd5; card_in = 1'b1;
    step();
    for (int k = 0; k < MAXT; k++) begin
      psw_valid = 1'b1; password_input = 16'(k);
      step();
      psw_valid = 1'b0;
      check("retry_lookup", 32'(ch_card_in), 32'd1);
      step(2);
      check("retry_wrong_psw", 32'(wrong_psw), 32'(k < MAXT - 1));
      check("retry_retained", 32'(card_retained), 32'(k == MAXT - 1));
    end
    step();
    check("retained_pulse_end", 32'(card_retained), 32'd0);
    check("retry_wrong_count", 32'(c_wrong - snap), 32'd2);
    check("retry_ret_count", 32'(c_ret - snap2), 32'd1);
    check("retry_no_eject", 32'(card_eject), 32'd0);
    step(3);
    psw_valid = 1'b1;
    step();
    psw_valid = 1'b0;
    check("retained_card_ignored", 32'(ch_card_in), 32'd0);
    card_in = 1'b0; ch_wrong_psw = 1'b0;
    step();
    card_in = 1'b1;
    step();
    psw_valid = 1'b1;
    step();
    psw_valid = 1'b0;
    check("reinsert_accepted", 32'(ch_card_in), 32'd1);
    card_in = 1'b0;  // pulled during lookup
    step(2);
    check("early_pull_no_eject", 32'(card_eject), 32'd0);
    check("early_pull_balance", 32'(balance), 32'd0);

    // reset mid-MENU
    login(6'd7, 16'h0BEE, 20'd500);
    snap = c_op_done;
    op_valid = 1'b1; op_code = 2'b01; amount = 20'd100;
    rst = 1'b1;
    #1;
    check("midrst_balance", 32'(balance), 32'd0);
    check("midrst_outputs", 32'({ch_card_in, op_done, txn_ok, card_eject}), 32'd0);
    check("midrst_latched", 32'({ch_card_number, ch_password}), 32'd0);
    step();
    rst = 1'b0; op_valid = 1'b0; card_in = 1'b0;
    step(2);
    check("midrst_no_write", 32'(c_op_done - snap), 32'd0);

    // funds check
    login(6'd1, 16'h0001, 20'd100);
    snap = c_op_done;
    do_op(2'b01, 20'd101);
    check("short_reject", 32'(txn_reject), 32'd1);
    check("short_no_ok", 32'(txn_ok), 32'd0);
    step();
    check("reject_one_cycle", 32'(txn_reject), 32'd0);
    check("short_balance", 32'(balance), 32'd100);
    check("short_no_write", 32'(c_op_done - snap), 32'd0);
    do_op(2'b01, 20'd100);
    check("exact_op_done", 32'(op_done), 32'd1);
    check("exact_updated", 32'(updated_balance), 32'd0);
    step();
    check("exact_balance", 32'(balance), 32'd0);
    logout();

    // deposit overflow
    login(6'd9, 16'h0009, 20'hFFFF0);
    do_op(2'b10, 20'h10);
    check("ovf_reject", 32'(txn_reject), 32'd1);
    check("ovf_no_write", 32'(op_done), 32'd0);
    check("ovf_balance", 32'(balance), 32'hFFFF0);
    do_op(2'b10, 20'hF);
    check("max_op_done", 32'(op_done), 32'd1);
    check("max_updated", 32'(updated_balance), 32'hFFFFF);
    step();
    check("max_balance", 32'(balance), 32'hFFFFF);
    logout();

    // unknown cards go straight to eject
    bad_cards[0] = 6'd12; bad_cards[1] = 6'(USERS);
    foreach (bad_cards[i]) begin
      card_number = bad_cards[i]; card_in = 1'b1;
      step();
      check("bad_card_eject", 32'(card_eject), 32'd1);
      check("bad_card_no_lookup", 32'(ch_card_in), 32'd0);
      step();
      card_in = 1'b0;
      step();
      check("bad_card_released", 32'(card_eject), 32'd0);
    end

    // PIN timeout
    snap = c_to;
    card_number = 6'd2; card_in = 1'b1;
    step();
    step(TO - 1);
    check("to_not_yet", 32'({timeout, card_eject}), 32'd0);
    step();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_eject", 32'(card_eject), 32'd1);
    step();
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_eject_held", 32'(card_eject), 32'd1);
    check("to_count", 32'(c_to - snap), 32'd1);
    card_in = 1'b0;
    step();

    // PIN on the expiry cycle wins, then MENU timeout
    ch_balance = 20'd77; ch_wrong_psw = 1'b0;
    card_in = 1'b1;
    step();
    step(TO - 1);
    psw_valid = 1'b1;
    step();
    psw_valid = 1'b0;
    check("psw_beats_timer", 32'(ch_card_in), 32'd1);
    check("psw_beats_timer_to", 32'(timeout), 32'd0);
    step(2);
    check("late_login_balance", 32'(balance), 32'd77);
    step(TO - 1);
    check("menu_to_not_yet", 32'({timeout, card_eject}), 32'd0);
    step();
    check("menu_to_pulse", 32'({timeout, card_eject}), 32'd3);
    card_in = 1'b0;
    step();

    // randomized operations against an arithmetic model
    mbal = longint'($urandom_range(0, 32'(LIM)));
    login(6'($urandom_range(0, USERS - 1)), 16'($urandom), 20'(mbal));
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = longint'($urandom_range(0, 32'(LIM)));
        1:       a = (op == 2) ? LIM - mbal : mbal;
        2:       a = (op == 2) ? LIM - mbal + 1 : mbal + 1;
        default: a = longint'($urandom_range(0, 1000));
      endcase
      if (a > LIM) a = LIM;
      exp_upd = 1'b0; exp_rej = 1'b0; exp_ok = 1'b0; nb = mbal;
      if (op == 0) exp_ok = 1'b1;
      else if (op == 1) begin
        if (a > mbal) exp_rej = 1'b1;
        else begin exp_upd = 1'b1; nb = mbal - a; end
      end else begin
        if (mbal + a > LIM) exp_rej = 1'b1;
        else begin exp_upd = 1'b1; nb = mbal + a; end
      end
      do_op(2'(op), 20'(a));
      check("rnd_op_done", 32'(op_done), 32'(exp_upd));
      check("rnd_txn_ok", 32'(txn_ok), 32'(exp_ok | exp_upd));
      check("rnd_reject", 32'(txn_reject), 32'(exp_rej));
      check("rnd_updated", 32'(updated_balance), exp_upd ? 32'(nb) : 32'd0);
      if (exp_upd) step();
      mbal = nb;
      check("rnd_balance", 32'(balance), 32'(mbal));
      step($urandom_range(0, 3));
    end

    // card pulled during the write: write completes, session ends
    snap = c_op_done; snap2 = c_eject;
    do_op(2'b01, '0);
    check("pull_upd_write", 32'(updated_balance), 32'(mbal));
    card_in = 1'b0;
    step();
    check("pull_upd_balance", 32'(balance), 32'd0);
    check("pull_upd_one_write", 32'(c_op_done - snap), 32'd1);
    step();
    check("pull_upd_no_eject", 32'(c_eject - snap2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
